// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: control/status bundle between the PLL supervisor and its environment
interface pll_lock_supervisor_if;
  logic       locked;
  logic       force_relock;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [7:0] retry_count;
  logic [7:0] lock_loss_count;
  modport master (
    input  locked, force_relock,
    output pll_resetb, sys_reset_n, ready, fault, retry_count, lock_loss_count
  );
  modport slave (
    output locked, force_relock,
    input  pll_resetb, sys_reset_n, ready, fault, retry_count, lock_loss_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL bring-up sequencer on the reference clock; define PLL_LOCK_LOSS_DEBOUNCE_EN to debounce lock loss in RUN
module pll_lock_supervisor #(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 4096,
  parameter int LOCK_TIMEOUT_CYCLES = 120000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input logic clock_in,
  input logic reset_n,
  pll_lock_supervisor_if.master bus
);
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT} state_t;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  state_t           r_state, w_next;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt, r_tmo;
  logic [7:0]       r_retry, r_llc;
  logic             r_pll_resetb, r_sys_reset_n, r_ready, r_fault;
  logic             w_locked_s, w_tmo, w_done, w_loss, w_retry_ok, w_retry_inc, w_lock_phase;
  assign w_locked_s   = r_sync[1];
  assign w_tmo        = r_tmo == TMO_LAST;
  assign w_done       = w_locked_s && r_cnt == STB_LAST;
  assign w_retry_ok   = r_retry < 8'(MAX_RETRIES);
  assign w_lock_phase = r_state == WAIT_LOCK || r_state == STABLE;
  // only a timeout can take the lock phase back to PLL_RST without a forced relock
  assign w_retry_inc  = !bus.force_relock && w_lock_phase && w_next == PLL_RST;
`ifdef PLL_LOCK_LOSS_DEBOUNCE_EN
  logic [1:0] r_deb;
  // count consecutive low cycles of the synced lock while running
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) r_deb <= 2'd0;
    else r_deb <= (r_state == RUN && !w_locked_s && !bus.force_relock) ? r_deb + 2'd1 : 2'd0;
  assign w_loss = r_state == RUN && !w_locked_s && r_deb == 2'd3;
`else
  assign w_loss = r_state == RUN && !w_locked_s;
`endif
  // next state; forced relock overrides everything, RUN entry beats timeout
  always_comb begin
    w_next = r_state;
    if (bus.force_relock) w_next = PLL_RST;
    else
      case (r_state)
        PLL_RST:   if (r_cnt == RST_LAST) w_next = WAIT_LOCK;
        WAIT_LOCK: if (w_tmo) w_next = w_retry_ok ? PLL_RST : FAULT;
                   else if (w_locked_s) w_next = STABLE;
        STABLE:    if (w_done) w_next = RUN;
                   else if (w_tmo) w_next = w_retry_ok ? PLL_RST : FAULT;
                   else if (!w_locked_s) w_next = WAIT_LOCK;
        RUN:       if (w_loss) w_next = PLL_RST;
        default:   w_next = FAULT;
      endcase
  end
  // state, synchroniser, counters and registered outputs
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) begin
      r_state       <= PLL_RST;
      r_sync        <= 2'b00;
      r_cnt         <= '0;
      r_tmo         <= '0;
      r_retry       <= 8'd0;
      r_llc         <= 8'd0;
      r_pll_resetb  <= 1'b0;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_sync        <= {r_sync[0], bus.locked};
      r_cnt         <= (w_next != r_state || bus.force_relock || !(r_state == PLL_RST || r_state == STABLE)) ? '0 : r_cnt + CNT_W'(1);
      r_tmo         <= (w_lock_phase && (w_next == WAIT_LOCK || w_next == STABLE)) ? r_tmo + CNT_W'(1) : '0;
      r_retry       <= (bus.force_relock || w_loss) ? 8'd0 : w_retry_inc ? r_retry + 8'd1 : r_retry;
      r_llc         <= (w_loss && !bus.force_relock && r_llc != 8'hFF) ? r_llc + 8'd1 : r_llc;
      r_pll_resetb  <= w_next == WAIT_LOCK || w_next == STABLE || w_next == RUN;
      r_sys_reset_n <= r_state == RUN && w_next == RUN;
      r_ready       <= r_state == RUN && w_next == RUN;
      r_fault       <= w_next == FAULT;
    end
  assign bus.pll_resetb      = r_pll_resetb;
  assign bus.sys_reset_n     = r_sys_reset_n;
  assign bus.ready           = r_ready;
  assign bus.fault           = r_fault;
  assign bus.retry_count     = r_retry;
  assign bus.lock_loss_count = r_llc;
endmodule
